reg_write_arbiter: RTL and testbench

Arbitrates the single register-file write port between two writeback requesters. Requester A is ALU writeback; requester B is memory-load writeback. Uses a valid/ready handshake with round-robin or fixed priority. Registers the winning address and data onto the register file's WRITE/INADDRESS/IN inputs for exactly one cycle, and keeps wrapping grant counters for debug.

---
 rtl/reg_write_arbiter_if.sv | 33 +++
 rtl/reg_write_arbiter.sv | 77 +++++++
 tb/tb_reg_write_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Writeback request/grant bus between two requesters and the register-file
// write port, including the debug grant counters.
interface reg_write_arbiter_if #(
    parameter int CNT_W = 8
);
    logic               i_hold;
    logic               i_a_valid;
    logic [2:0]         i_a_addr;
    logic signed [7:0]  i_a_data;
    logic               o_a_ready;
    logic               i_b_valid;
    logic [2:0]         i_b_addr;
    logic signed [7:0]  i_b_data;
    logic               o_b_ready;
    logic               o_write;
    logic [2:0]         o_inaddress;
    logic [7:0]         o_in;
    logic               o_last_gnt;
    logic [CNT_W-1:0]   o_gnt_cnt_a;
    logic [CNT_W-1:0]   o_gnt_cnt_b;

    modport master (
        output i_hold, i_a_valid, i_a_addr, i_a_data, i_b_valid, i_b_addr, i_b_data,
        input  o_a_ready, o_b_ready, o_write, o_inaddress, o_in, o_last_gnt,
               o_gnt_cnt_a, o_gnt_cnt_b
    );

    modport slave (
        input  i_hold, i_a_valid, i_a_addr, i_a_data, i_b_valid, i_b_addr, i_b_data,
        output o_a_ready, o_b_ready, o_write, o_inaddress, o_in, o_last_gnt,
               o_gnt_cnt_a, o_gnt_cnt_b
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester arbiter for the single register-file write port: one grant per
// cycle, round-robin or A-first, with a registered one-cycle write strobe.
module reg_write_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    reg_write_arbiter_if.slave bus
);

    logic             w_a_ready;
    logic             w_b_ready;
    logic             r_write;
    logic [2:0]       r_inaddress;
    logic [7:0]       r_in;
    logic             r_last_gnt;
    logic [CNT_W-1:0] r_gnt_cnt_a;
    logic [CNT_W-1:0] r_gnt_cnt_b;

    // Grant selection; on a conflict the requester that did not win last time goes next
    always_comb begin
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
        if (bus.i_hold) begin
            w_a_ready = 1'b0;
            w_b_ready = 1'b0;
        end else if (bus.i_a_valid && bus.i_b_valid) begin
            if (FIXED_PRIO == 1'b1) begin
                w_a_ready = 1'b1;
                w_b_ready = 1'b0;
            end else begin
                w_a_ready = r_last_gnt;
                w_b_ready = ~r_last_gnt;
            end
        end else begin
            w_a_ready = bus.i_a_valid;
            w_b_ready = bus.i_b_valid;
        end
    end

    // Write-port registers, grant history and wrapping grant counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_write     <= 1'b0;
            r_inaddress <= 3'd0;
            r_in        <= 8'd0;
            r_last_gnt  <= 1'b1;
            r_gnt_cnt_a <= {CNT_W{1'b0}};
            r_gnt_cnt_b <= {CNT_W{1'b0}};
        end else if (bus.i_a_valid && w_a_ready) begin
            r_write     <= 1'b1;
            r_inaddress <= bus.i_a_addr;
            r_in        <= bus.i_a_data;
            r_last_gnt  <= 1'b0;
            r_gnt_cnt_a <= r_gnt_cnt_a + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (bus.i_b_valid && w_b_ready) begin
            r_write     <= 1'b1;
            r_inaddress <= bus.i_b_addr;
            r_in        <= bus.i_b_data;
            r_last_gnt  <= 1'b1;
            r_gnt_cnt_b <= r_gnt_cnt_b + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_write     <= 1'b0;
        end
    end

    assign bus.o_a_ready   = w_a_ready;
    assign bus.o_b_ready   = w_b_ready;
    assign bus.o_write     = r_write;
    assign bus.o_inaddress = r_inaddress;
    assign bus.o_in        = r_in;
    assign bus.o_last_gnt  = r_last_gnt;
    assign bus.o_gnt_cnt_a = r_gnt_cnt_a;
    assign bus.o_gnt_cnt_b = r_gnt_cnt_b;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench: a round-robin instance (CNT_W=8) and a fixed-priority
// instance (CNT_W=2) driven through a linear sequence of hand-computed steps.
module tb_reg_write_arbiter;

    logic clk;
    logic rst0;
    logic rst1;
    int   n_checks;
    int   n_fail;

    reg_write_arbiter_if #(.CNT_W(8)) f0 ();
    reg_write_arbiter_if #(.CNT_W(2)) f1 ();

    reg_write_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(8)) dut_rr (
        .i_clk (clk),
        .i_rst (rst0),
        .bus   (f0)
    );

    reg_write_arbiter #(.FIXED_PRIO(1'b1), .CNT_W(2)) dut_fx (
        .i_clk (clk),
        .i_rst (rst1),
        .bus   (f1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        f0.i_hold = 1'b0; f0.i_a_valid = 1'b0; f0.i_a_addr = 3'd0; f0.i_a_data = 8'sd0;
        f0.i_b_valid = 1'b0; f0.i_b_addr = 3'd0; f0.i_b_data = 8'sd0;
        f1.i_hold = 1'b0; f1.i_a_valid = 1'b0; f1.i_a_addr = 3'd0; f1.i_a_data = 8'sd0;
        f1.i_b_valid = 1'b0; f1.i_b_addr = 3'd0; f1.i_b_data = 8'sd0;
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // reset state
        check("rst_write",   32'(f0.o_write),     32'd0);
        check("rst_addr",    32'(f0.o_inaddress), 32'd0);
        check("rst_in",      32'(f0.o_in),        32'd0);
        check("rst_last",    32'(f0.o_last_gnt),  32'd1);
        check("rst_cnt_a",   32'(f0.o_gnt_cnt_a), 32'd0);
        check("rst_cnt_b",   32'(f0.o_gnt_cnt_b), 32'd0);
        check("rst_fx_last", 32'(f1.o_last_gnt),  32'd1);

        // single requester A: R3 <= -5
        f0.i_a_valid = 1'b1; f0.i_a_addr = 3'd3; f0.i_a_data = -8'sd5;
        #1;
        check("single_a_ready", 32'(f0.o_a_ready), 32'd1);
        check("single_b_ready", 32'(f0.o_b_ready), 32'd0);
        step();
        f0.i_a_valid = 1'b0;
        check("single_write", 32'(f0.o_write),     32'd1);
        check("single_addr",  32'(f0.o_inaddress), 32'd3);
        check("single_in",    32'(f0.o_in),        32'hFB);
        check("single_cnt_a", 32'(f0.o_gnt_cnt_a), 32'd1);
        check("single_last",  32'(f0.o_last_gnt),  32'd0);
        step();
        check("single_write_drop", 32'(f0.o_write),     32'd0);
        check("single_addr_hold",  32'(f0.o_inaddress), 32'd3);
        check("single_in_hold",    32'(f0.o_in),        32'hFB);

        // mid-stream asynchronous reset while a write is in flight
        f0.i_a_valid = 1'b1; f0.i_a_addr = 3'd6; f0.i_a_data = 8'sh7F;
        step();
        check("pre_rst_write", 32'(f0.o_write), 32'd1);
        #2;
        rst0 = 1'b1;
        #1;
        check("async_rst_write", 32'(f0.o_write),     32'd0);
        check("async_rst_addr",  32'(f0.o_inaddress), 32'd0);
        check("async_rst_in",    32'(f0.o_in),        32'd0);
        check("async_rst_last",  32'(f0.o_last_gnt),  32'd1);
        check("async_rst_cnt_a", 32'(f0.o_gnt_cnt_a), 32'd0);
        f0.i_a_valid = 1'b0;
        @(negedge clk);
        rst0 = 1'b0;
        check("post_rst_write", 32'(f0.o_write), 32'd0);

        // round-robin conflict: A(R1,0x11) and B(R2,0x22) held valid
        f0.i_a_valid = 1'b1; f0.i_a_addr = 3'd1; f0.i_a_data = 8'sh11;
        f0.i_b_valid = 1'b1; f0.i_b_addr = 3'd2; f0.i_b_data = 8'sh22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_a_ready", 32'(f0.o_a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_b_ready", 32'(f0.o_b_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            step();
            check("rr_write", 32'(f0.o_write),     32'd1);
            check("rr_addr",  32'(f0.o_inaddress), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_in",    32'(f0.o_in),        (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        check("rr_cnt_a", 32'(f0.o_gnt_cnt_a), 32'd2);
        check("rr_cnt_b", 32'(f0.o_gnt_cnt_b), 32'd2);

        // HOLD with both valid; the write registered just before still completes
        f0.i_hold = 1'b1;
        #1;
        check("hold_inflight_write", 32'(f0.o_write), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("hold_a_ready", 32'(f0.o_a_ready), 32'd0);
            check("hold_b_ready", 32'(f0.o_b_ready), 32'd0);
            step();
            check("hold_write", 32'(f0.o_write), 32'd0);
        end
        check("hold_cnt_a", 32'(f0.o_gnt_cnt_a), 32'd2);
        check("hold_cnt_b", 32'(f0.o_gnt_cnt_b), 32'd2);
        check("hold_last",  32'(f0.o_last_gnt),  32'd1);
        f0.i_hold = 1'b0;
        #1;
        check("unhold_a_ready", 32'(f0.o_a_ready), 32'd1);
        check("unhold_b_ready", 32'(f0.o_b_ready), 32'd0);
        step();
        check("unhold_addr", 32'(f0.o_inaddress), 32'd1);
        check("unhold_last", 32'(f0.o_last_gnt),  32'd0);

        // same-address race with LAST_GNT=0: B first, then A
        f0.i_a_addr = 3'd5; f0.i_a_data = 8'sh01;
        f0.i_b_addr = 3'd5; f0.i_b_data = 8'sh02;
        #1;
        check("race_b_ready", 32'(f0.o_b_ready), 32'd1);
        step();
        check("race_first_addr", 32'(f0.o_inaddress), 32'd5);
        check("race_first_in",   32'(f0.o_in),        32'h02);
        f0.i_b_valid = 1'b0;
        #1;
        check("race_a_ready", 32'(f0.o_a_ready), 32'd1);
        step();
        f0.i_a_valid = 1'b0;
        check("race_second_write", 32'(f0.o_write),     32'd1);
        check("race_second_addr",  32'(f0.o_inaddress), 32'd5);
        check("race_second_in",    32'(f0.o_in),        32'h01);
        step();
        check("race_done_write", 32'(f0.o_write), 32'd0);

        // fixed priority: A(R4,0x44) always wins while both are valid
        f1.i_a_valid = 1'b1; f1.i_a_addr = 3'd4; f1.i_a_data = 8'sh44;
        f1.i_b_valid = 1'b1; f1.i_b_addr = 3'd7; f1.i_b_data = 8'sh77;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("fx_a_ready", 32'(f1.o_a_ready), 32'd1);
            check("fx_b_ready", 32'(f1.o_b_ready), 32'd0);
            step();
            check("fx_addr", 32'(f1.o_inaddress), 32'd4);
        end
        check("fx_cnt_a3", 32'(f1.o_gnt_cnt_a), 32'd3);
        f1.i_a_valid = 1'b0;
        #1;
        check("fx_b_ready_after", 32'(f1.o_b_ready), 32'd1);
        step();
        f1.i_b_valid = 1'b0;
        check("fx_b_addr",  32'(f1.o_inaddress), 32'd7);
        check("fx_b_in",    32'(f1.o_in),        32'h77);
        check("fx_cnt_b",   32'(f1.o_gnt_cnt_b), 32'd1);

        // counter wrap with CNT_W=2: two more A grants make five, reading 1
        f1.i_a_valid = 1'b1;
        step();
        check("wrap_cnt_a4", 32'(f1.o_gnt_cnt_a), 32'd0);
        step();
        f1.i_a_valid = 1'b0;
        check("wrap_cnt_a5", 32'(f1.o_gnt_cnt_a), 32'd1);
        check("wrap_write",  32'(f1.o_write),     32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
